// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, host) and the memory.
// The arbiter connects through the slave modport and the environment through the master modport.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with *_we/*_addr/*_wdata and holds them stable
  // until *_ack. *_ack is a one-cycle pulse, and *_err/*_rdata are meaningful only while it
  // is high. A req still high in the cycle after ack starts a new access.
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_ack;
  logic              c_err;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [DATA_W-1:0] h_rdata;
  logic              h_ack;
  logic              h_err;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack, c_err,
    input  h_req, h_we, h_addr, h_wdata,
    output h_rdata, h_ack, h_err,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack, c_err,
    output h_req, h_we, h_addr, h_wdata,
    input  h_rdata, h_ack, h_err,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter (CPU load/store unit vs host) in front of a single-port, byte-addressed data memory.
// Each access is a grant cycle (IDLE) and an ack cycle (WAIT); the block also counts CPU stall cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 128
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      host_lock,
  input  logic                      stall_clr,
  dmem_port_arbiter_if.slave        bus,
  output logic                      busy,
  output logic [15:0]               cpu_stall_cnt,
  output logic                      dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - 4);

  state_e      state_q, state_d;
  logic        gnt_host_q, gnt_host_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        last_host_q, last_host_d;
  logic [15:0] stall_q, stall_d;

  logic              c_elig;
  logic              h_elig;
  logic              grant;
  logic              pick_host;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic              cpu_gnt;
  logic              cpu_ack;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_host_q  <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      last_host_q <= 1'b1;
      stall_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      gnt_host_q  <= gnt_host_d;
      we_q        <= we_d;
      err_q       <= err_d;
      last_host_q <= last_host_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_host_d  = gnt_host_q;
    we_d        = we_q;
    err_d       = err_q;
    last_host_d = last_host_q;

    c_elig    = bus.c_req & ~host_lock;
    h_elig    = bus.h_req;
    grant     = 1'b0;
    pick_host = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_err   = 1'b0;

    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.c_ack   = 1'b0;
    bus.c_err   = 1'b0;
    bus.c_rdata = '0;
    bus.h_ack   = 1'b0;
    bus.h_err   = 1'b0;
    bus.h_rdata = '0;

    case (state_q)
      S_IDLE: begin
        // Gating with reset_n keeps the memory strobe quiet while reset is held.
        if (reset_n && (c_elig || h_elig)) begin
          grant     = 1'b1;
          pick_host = h_elig & (~c_elig | ~last_host_q);
          sel_we    = pick_host ? bus.h_we    : bus.c_we;
          sel_addr  = pick_host ? bus.h_addr  : bus.c_addr;
          sel_wdata = pick_host ? bus.h_wdata : bus.c_wdata;
          sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);

          state_d     = S_WAIT;
          gnt_host_d  = pick_host;
          we_d        = sel_we;
          err_d       = sel_err;
          last_host_d = pick_host;

          if (!sel_err) begin
            bus.m_en    = 1'b1;
            bus.m_we    = sel_we;
            bus.m_addr  = sel_addr;
            bus.m_wdata = sel_wdata;
          end
        end
      end
      S_WAIT: begin
        state_d = S_IDLE;
        if (gnt_host_q) begin
          bus.h_ack   = 1'b1;
          bus.h_err   = err_q;
          bus.h_rdata = (we_q || err_q) ? '0 : bus.m_rdata;
        end else begin
          bus.c_ack   = 1'b1;
          bus.c_err   = err_q;
          bus.c_rdata = (we_q || err_q) ? '0 : bus.m_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A CPU request is not a stall in the cycle it is granted nor in the cycle it is acked.
  always_comb begin
    cpu_gnt = grant & ~pick_host;
    cpu_ack = (state_q == S_WAIT) & ~gnt_host_q;
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = 16'h0000;
    end else if (bus.c_req && !cpu_gnt && !cpu_ack && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end
  end

  assign busy          = (state_q == S_WAIT);
  assign cpu_stall_cnt = stall_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: single-access vector table plus hand-written
// sequences for arbitration, host lock, stall saturation and reset during an access.
module tb_dmem_port_arbiter;

  logic        CLOCK_50;
  logic        reset_n;
  logic        host_lock;
  logic        stall_clr;
  logic        busy;
  logic [15:0] cpu_stall_cnt;
  logic        dbg_state;

  int n_checks;
  int n_fail;

  dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .DEPTH_BYTES(128)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .host_lock     (host_lock),
    .stall_clr     (stall_clr),
    .bus           (bus.slave),
    .busy          (busy),
    .cpu_stall_cnt (cpu_stall_cnt),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // big-endian byte memory, synchronous read with one cycle latency
  logic [7:0] mem [0:127];
  always @(posedge CLOCK_50) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        mem[bus.m_addr[6:0]]         <= bus.m_wdata[31:24];
        mem[bus.m_addr[6:0] + 7'd1]  <= bus.m_wdata[23:16];
        mem[bus.m_addr[6:0] + 7'd2]  <= bus.m_wdata[15:8];
        mem[bus.m_addr[6:0] + 7'd3]  <= bus.m_wdata[7:0];
      end else begin
        bus.m_rdata <= {mem[bus.m_addr[6:0]], mem[bus.m_addr[6:0] + 7'd1],
                        mem[bus.m_addr[6:0] + 7'd2], mem[bus.m_addr[6:0] + 7'd3]};
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    host_lock   = 1'b0;
    stall_clr   = 1'b0;
    bus.c_req   = 1'b0;
    bus.c_we    = 1'b0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    bus.h_req   = 1'b0;
    bus.h_we    = 1'b0;
    bus.h_addr  = '0;
    bus.h_wdata = '0;
  endtask

  typedef struct packed {
    logic        host;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  // driver: one access from an idle arbiter, checked in its grant and ack cycles
  task automatic do_access(input int idx, input vec_t v);
    logic ack, other_ack, err;
    logic [31:0] rdata;
    @(negedge CLOCK_50);
    if (v.host) begin
      bus.h_req = 1'b1; bus.h_we = v.we; bus.h_addr = v.addr; bus.h_wdata = v.wdata;
    end else begin
      bus.c_req = 1'b1; bus.c_we = v.we; bus.c_addr = v.addr; bus.c_wdata = v.wdata;
    end
    #1;
    check($sformatf("v%0d grant m_en", idx), 32'(bus.m_en), 32'(!v.exp_err));
    if (!v.exp_err) begin
      check($sformatf("v%0d grant m_we", idx), 32'(bus.m_we), 32'(v.we));
      check($sformatf("v%0d grant m_addr", idx), 32'(bus.m_addr), 32'(v.addr));
    end
    @(negedge CLOCK_50);
    ack       = v.host ? bus.h_ack   : bus.c_ack;
    other_ack = v.host ? bus.c_ack   : bus.h_ack;
    err       = v.host ? bus.h_err   : bus.c_err;
    rdata     = v.host ? bus.h_rdata : bus.c_rdata;
    check($sformatf("v%0d ack", idx), 32'(ack), 32'd1);
    check($sformatf("v%0d other ack", idx), 32'(other_ack), 32'd0);
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
    check($sformatf("v%0d wait m_en", idx), 32'(bus.m_en), 32'd0);
    bus.c_req = 1'b0;
    bus.h_req = 1'b0;
  endtask

  initial begin
    int h_acks, c_acks;
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();

    vecs[0]  = '{1'b1, 1'b1, 12'h000, 32'h11223344, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'h11223344};
    vecs[2]  = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 12'h010, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 12'h010, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b1, 12'h07C, 32'hA5A55A5A, 1'b0, 32'h00000000};
    vecs[6]  = '{1'b0, 1'b0, 12'h07C, 32'h00000000, 1'b0, 32'hA5A55A5A};
    vecs[7]  = '{1'b0, 1'b0, 12'h006, 32'h00000000, 1'b1, 32'h00000000};
    vecs[8]  = '{1'b0, 1'b0, 12'h080, 32'h00000000, 1'b1, 32'h00000000};
    vecs[9]  = '{1'b1, 1'b1, 12'h002, 32'hFFFFFFFF, 1'b1, 32'h00000000};
    vecs[10] = '{1'b0, 1'b1, 12'h080, 32'hFFFFFFFF, 1'b1, 32'h00000000};
    vecs[11] = '{1'b1, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'h11223344};

    // reset state
    reset_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("rst busy", 32'(busy), 32'd0);
    check("rst stall", 32'(cpu_stall_cnt), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    check("rst m_en", 32'(bus.m_en), 32'd0);
    check("rst acks", 32'({bus.c_ack, bus.h_ack, bus.c_err, bus.h_err}), 32'd0);
    reset_n = 1'b1;

    // both requesters held right after reset: CPU first, then alternate
    @(negedge CLOCK_50);
    bus.c_req = 1'b1; bus.c_addr = 12'h000;
    bus.h_req = 1'b1; bus.h_addr = 12'h004;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLOCK_50);
      check($sformatf("alt c_ack k%0d", k), 32'(bus.c_ack), 32'(k == 1 || k == 5));
      check($sformatf("alt h_ack k%0d", k), 32'(bus.h_ack), 32'(k == 3 || k == 7));
      if (k == 1) check("alt stall 1st c_ack", 32'(cpu_stall_cnt), 32'd0);
      if (k == 5) check("alt stall 2nd c_ack", 32'(cpu_stall_cnt), 32'd2);
    end
    bus.c_req = 1'b0;
    bus.h_req = 1'b0;

    // single-access vector table
    for (int i = 0; i < 12; i++) do_access(i, vecs[i]);
    check("mem byte0", 32'(mem[0]), 32'h11);
    check("mem byte1", 32'(mem[1]), 32'h22);
    check("mem byte2", 32'(mem[2]), 32'h33);
    check("mem byte3", 32'(mem[3]), 32'h44);
    check("mem byte7f", 32'(mem[127]), 32'h5A);

    // host lock: CPU held 10 cycles while the host completes two accesses
    @(negedge CLOCK_50);
    stall_clr = 1'b1;
    @(negedge CLOCK_50);
    stall_clr = 1'b0;
    check("lock stall clr", 32'(cpu_stall_cnt), 32'd0);
    host_lock = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 12'h010;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 12'h000;
    h_acks = 0;
    c_acks = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLOCK_50);
      if (bus.c_ack) c_acks++;
      if (bus.h_ack) h_acks++;
      bus.h_req = (i < 4);
    end
    check("lock c_acks", 32'(c_acks), 32'd0);
    check("lock h_acks", 32'(h_acks), 32'd2);
    check("lock stall", 32'(cpu_stall_cnt), 32'd10);
    host_lock = 1'b0;
    @(negedge CLOCK_50);
    check("unlock c_ack", 32'(bus.c_ack), 32'd1);
    check("unlock c_rdata", bus.c_rdata, 32'hDEADBEEF);
    check("unlock stall", 32'(cpu_stall_cnt), 32'd10);
    bus.c_req = 1'b0;

    // stall counter saturation and clear priority
    @(negedge CLOCK_50);
    stall_clr = 1'b1;
    @(negedge CLOCK_50);
    stall_clr = 1'b0;
    host_lock = 1'b1;
    bus.c_req = 1'b1;
    repeat (65534) @(negedge CLOCK_50);
    check("sat fffe", 32'(cpu_stall_cnt), 32'h0000FFFE);
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLOCK_50);
      check($sformatf("sat hold %0d", i), 32'(cpu_stall_cnt), 32'h0000FFFF);
    end
    stall_clr = 1'b1;
    @(negedge CLOCK_50);
    check("sat clr", 32'(cpu_stall_cnt), 32'd0);
    stall_clr = 1'b0;
    @(negedge CLOCK_50);
    check("sat recount", 32'(cpu_stall_cnt), 32'd1);
    bus.c_req = 1'b0;
    host_lock = 1'b0;

    // reset during the WAIT cycle of a host write
    @(negedge CLOCK_50);
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 12'h020; bus.h_wdata = 32'hCAFEF00D;
    @(posedge CLOCK_50);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst h_ack", 32'(bus.h_ack), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst m_en", 32'(bus.m_en), 32'd0);
    check("midrst state", 32'(dbg_state), 32'd0);
    check("midrst stall", 32'(cpu_stall_cnt), 32'd0);
    bus.h_req = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    check("midrst mem", {mem[32], mem[33], mem[34], mem[35]}, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLOCK_50);
      check($sformatf("midrst no ack %0d", i), 32'({bus.h_ack, bus.c_ack}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
